// File: rtl/accel_hub_pkg.sv
// Shared definitions for the accelerator hub and the CPU that drives it.
// Holds the accelerator id width, the reserved loopback id and id helpers.
// No logic; imported by the hub, its FIFO and its interface.
package accel_hub_pkg;

  localparam int ACCEL_ID_WIDTH = 4;

  typedef logic [ACCEL_ID_WIDTH-1:0] accel_id_t;

  // Id 15 is never a real channel; it is reserved for the CPU self-test loopback.
  localparam accel_id_t ACCEL_LOOPBACK_ID = 4'd15;

  // True when the id addresses one of the first 'count' real channels.
  function automatic logic id_is_channel(input accel_id_t id, input int count);
    return (int'(id) < count);
  endfunction

endpackage

// File: rtl/accel_hub_if.sv
// Bundles the CPU accelerator port and the per-channel accelerator streams.
// slave: the hub side; master: the CPU plus accelerators driving the hub.
// Pure wiring, no storage or latency of its own.
interface accel_hub_if #(
  parameter int ACCEL_COUNT = 4,
  parameter int REG_WIDTH   = 16
);
  import accel_hub_pkg::*;

  // CPU side
  accel_id_t                        accel_id;
  logic                             accel_can_read;
  logic                             accel_can_write;
  logic                             accel_read_enable;
  logic [REG_WIDTH-1:0]             accel_read_data;
  logic                             accel_write_enable;
  logic [REG_WIDTH-1:0]             accel_write_data;

  // Accelerator streams, channel k at [k*REG_WIDTH +: REG_WIDTH]
  logic [ACCEL_COUNT-1:0]           acc_in_valid;
  logic [ACCEL_COUNT-1:0]           acc_in_ready;
  logic [ACCEL_COUNT*REG_WIDTH-1:0] acc_in_data;
  logic [ACCEL_COUNT-1:0]           acc_out_valid;
  logic [ACCEL_COUNT-1:0]           acc_out_ready;
  logic [ACCEL_COUNT*REG_WIDTH-1:0] acc_out_data;

  modport slave (
    input  accel_id, accel_read_enable, accel_write_enable, accel_write_data,
    input  acc_in_valid, acc_in_data, acc_out_ready,
    output accel_can_read, accel_can_write, accel_read_data,
    output acc_in_ready, acc_out_valid, acc_out_data
  );

  modport master (
    output accel_id, accel_read_enable, accel_write_enable, accel_write_data,
    output acc_in_valid, acc_in_data, acc_out_ready,
    input  accel_can_read, accel_can_write, accel_read_data,
    input  acc_in_ready, acc_out_valid, acc_out_data
  );

endinterface

// File: rtl/accel_hub_fifo.sv
// Small circular FIFO used for every hub channel direction.
// Latency: a push into an empty FIFO is visible at head one cycle later.
// Backpressure: push ignored when full (even with a same-cycle pop); pop ignored when empty.
module accel_hub_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-edge count, so a full FIFO never accepts a push.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap on their natural width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/accel_hub.sv
// Shares the CPU accelerator port among ACCEL_COUNT channels, each with an rx and tx FIFO.
// Latency: CPU status/data combinational from accel_id; stream push visible one cycle later.
// Backpressure: acc_in_ready = rx not full; can_write = tx not full; ACCEL_HUB_LOOPBACK_EN adds id 15 loopback.
module accel_hub
  import accel_hub_pkg::*;
#(
  parameter int ACCEL_COUNT = 4,
  parameter int REG_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  accel_hub_if.slave    bus
);

  logic [ACCEL_COUNT-1:0]           rx_full;
  logic [ACCEL_COUNT-1:0]           rx_empty;
  logic [ACCEL_COUNT-1:0]           rx_pop;
  logic [REG_WIDTH-1:0]             rx_head [ACCEL_COUNT];
  logic [ACCEL_COUNT-1:0]           tx_full;
  logic [ACCEL_COUNT-1:0]           tx_empty;
  logic [ACCEL_COUNT-1:0]           tx_push;
  logic [ACCEL_COUNT*REG_WIDTH-1:0] tx_head;

  logic                             sel_can_read;
  logic                             sel_can_write;
  logic [REG_WIDTH-1:0]             sel_data;

  for (genvar k = 0; k < ACCEL_COUNT; k++) begin : g_chan
    // CPU enables reach only the channel whose id matches; the FIFO ignores
    // a pop when empty and a push when full, so no extra qualification is needed.
    assign rx_pop[k]  = bus.accel_read_enable  && (bus.accel_id == accel_id_t'(k));
    assign tx_push[k] = bus.accel_write_enable && (bus.accel_id == accel_id_t'(k));

    accel_hub_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REG_WIDTH)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.acc_in_valid[k]),
      .data  (bus.acc_in_data[k*REG_WIDTH +: REG_WIDTH]),
      .pop   (rx_pop[k]),
      .full  (rx_full[k]),
      .empty (rx_empty[k]),
      .head  (rx_head[k])
    );

    accel_hub_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REG_WIDTH)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push[k]),
      .data  (bus.accel_write_data),
      .pop   (bus.acc_out_ready[k]),
      .full  (tx_full[k]),
      .empty (tx_empty[k]),
      .head  (tx_head[k*REG_WIDTH +: REG_WIDTH])
    );
  end

`ifdef ACCEL_HUB_LOOPBACK_EN
  logic                 lb_full;
  logic                 lb_empty;
  logic [REG_WIDTH-1:0] lb_head;

  accel_hub_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REG_WIDTH)) u_loopback (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.accel_write_enable && (bus.accel_id == ACCEL_LOOPBACK_ID)),
    .data  (bus.accel_write_data),
    .pop   (bus.accel_read_enable && (bus.accel_id == ACCEL_LOOPBACK_ID)),
    .full  (lb_full),
    .empty (lb_empty),
    .head  (lb_head)
  );
`endif

  // Select the addressed channel's status and rx head; unmapped ids read as idle zero.
  always_comb begin
    sel_can_read  = 1'b0;
    sel_can_write = 1'b0;
    sel_data      = '0;
    for (int k = 0; k < ACCEL_COUNT; k++) begin
      if (bus.accel_id == accel_id_t'(k)) begin
        sel_can_read  = !rx_empty[k];
        sel_can_write = !tx_full[k];
        sel_data      = rx_head[k];
      end
    end
`ifdef ACCEL_HUB_LOOPBACK_EN
    if (bus.accel_id == ACCEL_LOOPBACK_ID) begin
      sel_can_read  = !lb_empty;
      sel_can_write = !lb_full;
      sel_data      = lb_head;
    end
`endif
  end

  // Hold every handshake idle while rst is high, before the FIFO state has cleared.
  assign bus.accel_can_read  = sel_can_read && !rst;
  assign bus.accel_can_write = sel_can_write && !rst;
  assign bus.accel_read_data = sel_data;
  assign bus.acc_in_ready    = ~rx_full & {ACCEL_COUNT{!rst}};
  assign bus.acc_out_valid   = ~tx_empty & {ACCEL_COUNT{!rst}};
  assign bus.acc_out_data    = tx_head;

endmodule
